// File: rtl/camera_pkg.sv
// Shared types for the camera windowing block: FSM state encoding and
// decimation codes.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_INFRAME = 2'd2
  } state_t;

  localparam logic [1:0] DECIM_1_1  = 2'd0;
  localparam logic [1:0] DECIM_1_2  = 2'd1;
  localparam logic [1:0] DECIM_1_4  = 2'd2;
  localparam logic [1:0] DECIM_RSVD = 2'd3;

  // Decimation code to shift amount; the reserved code behaves as 1:1.
  function automatic logic [1:0] decim_shift(input logic [1:0] code);
    return (code == DECIM_RSVD) ? DECIM_1_1 : code;
  endfunction

endpackage

// File: rtl/camera_window_if.sv
// Windowed pixel output bus of camera_window.
interface camera_window_if #(
  parameter int DW = 10,
  parameter int XW = 10,
  parameter int YW = 9
);
  // PIXEL_VALID qualifies DATA_OUT/X_OUT/Y_OUT for exactly one cycle; there is
  // no ready, so the consumer must take every beat it sees.
  logic [DW-1:0] DATA_OUT;
  logic [XW-1:0] X_OUT;
  logic [YW-1:0] Y_OUT;
  logic          PIXEL_VALID;
  logic          FRAME_START;
  logic          FRAME_END;

  modport master (
    output DATA_OUT, X_OUT, Y_OUT, PIXEL_VALID, FRAME_START, FRAME_END
  );

  modport slave (
    input DATA_OUT, X_OUT, Y_OUT, PIXEL_VALID, FRAME_START, FRAME_END
  );
endinterface

// File: rtl/camera_window_axis.sv
// One axis (column or line) of the window: raw counter, window compare,
// decimation mask and window-relative decimated coordinate.
module camera_window_axis
  import camera_pkg::*;
#(
  parameter int MAX        = 752,
  parameter bit SAT_AT_MAX = 1'b0,
  localparam int CW = $clog2(MAX) + 1,
  localparam int OW = $clog2(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] org_in,
  input  logic [CW-1:0] size_in,
  input  logic          inc,
  input  logic          clr,
  input  logic [1:0]    shift,
  output logic [CW-1:0] cnt,
  output logic          hit,
  output logic [OW-1:0] rel
);

  localparam logic [CW-1:0] LIMIT = SAT_AT_MAX ? CW'(MAX) : {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] org_q, org_d;
  logic [CW-1:0] size_q, size_d;
  logic [CW:0]   end_x;
  logic [OW-1:0] diff;
  logic [OW-1:0] mask;

  always_comb begin
    cnt_d  = cnt_q;
    org_d  = org_q;
    size_d = size_q;
    if (load) begin
      org_d  = org_in;
      size_d = size_in;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      org_q  <= '0;
      size_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      org_q  <= org_d;
      size_q <= size_d;
    end
  end

  // Low bits suffice for the offset: inside the window it is below MAX.
  always_comb begin
    end_x = {1'b0, org_q} + {1'b0, size_q};
    diff  = cnt_q[OW-1:0] - org_q[OW-1:0];
    case (shift)
      DECIM_1_2: mask = OW'(1);
      DECIM_1_4: mask = OW'(3);
      default:   mask = '0;
    endcase
    hit = (cnt_q < CW'(MAX)) && (cnt_q >= org_q) &&
          ({1'b0, cnt_q} < end_x) && ((diff & mask) == '0);
    rel = diff >> shift;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/camera_window.sv
// Sensor window/decimation block: registers sensor sync, tracks frames and
// emits window-relative pixels with a fixed two-cycle latency.
module camera_window
  import camera_pkg::*;
#(
  parameter int DW  = 10,
  parameter int H   = 752,
  parameter int V   = 480,
  parameter int FCW = 16
) (
  input  logic                PIXCLK,
  input  logic                RST_N,
  input  logic                LINE_VALID,
  input  logic                FRAME_VALID,
  input  logic [DW-1:0]       DATA_IN,
  input  logic [$clog2(H):0]  WIN_X0,
  input  logic [$clog2(H):0]  WIN_W,
  input  logic [$clog2(V):0]  WIN_Y0,
  input  logic [$clog2(V):0]  WIN_H,
  input  logic [1:0]          DECIM,
  input  logic                ERR_CLR,
  camera_window_if.master     pix,
  output logic [FCW-1:0]      FRAME_COUNT,
  output logic                LINE_ERR,
  output logic                OVF_ERR,
  output state_t              STATE_DBG
);

  localparam int XCW = $clog2(H) + 1;
  localparam int YCW = $clog2(V) + 1;
  localparam int XOW = $clog2(H);
  localparam int YOW = $clog2(V);

  state_t         state_q, state_d;
  logic           lv_s1_q, fv_s1_q, s1_vld_q, lv_p_q, fv_p_q;
  logic [DW-1:0]  data_s1_q;
  logic [1:0]     decim_q, decim_d;
  logic [DW-1:0]  data_out_q, data_out_d;
  logic [XOW-1:0] x_q, x_d;
  logic [YOW-1:0] y_q, y_d;
  logic           pv_q, pv_d;
  logic           fs_q, fe_q;
  logic [FCW-1:0] fc_q, fc_d;
  logic           line_err_q, line_err_d;
  logic           ovf_err_q, ovf_err_d;

  logic           fs_go, fe_go, in_frame;
  logic           fv_rise, fv_fall, lv_rise, lv_fall;
  logic [XCW-1:0] col_cnt;
  logic [YCW-1:0] row_cnt;
  logic           col_hit, row_hit;
  logic [XOW-1:0] col_rel;
  logic [YOW-1:0] row_rel;

  assign in_frame = (state_q == ST_INFRAME);
  assign fv_rise  = fv_s1_q & ~fv_p_q;
  assign fv_fall  = ~fv_s1_q & fv_p_q;
  assign lv_rise  = lv_s1_q & ~lv_p_q;
  assign lv_fall  = ~lv_s1_q & lv_p_q;

  // SYNC only leaves once a genuine low FRAME_VALID has passed stage 1, so a
  // frame already running at reset release is never captured.
  always_comb begin
    state_d = state_q;
    fs_go   = 1'b0;
    fe_go   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (s1_vld_q && !fv_s1_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (fv_rise) begin
          state_d = ST_INFRAME;
          fs_go   = 1'b1;
        end
      end
      ST_INFRAME: begin
        if (fv_fall) begin
          state_d = ST_ARMED;
          fe_go   = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  camera_window_axis #(.MAX(H), .SAT_AT_MAX(1'b0)) u_col (
    .clk     (PIXCLK),
    .rst_n   (RST_N),
    .load    (fs_go),
    .org_in  (WIN_X0),
    .size_in (WIN_W),
    .inc     (in_frame & lv_s1_q),
    .clr     (fs_go | ~lv_s1_q),
    .shift   (decim_q),
    .cnt     (col_cnt),
    .hit     (col_hit),
    .rel     (col_rel)
  );

  camera_window_axis #(.MAX(V), .SAT_AT_MAX(1'b1)) u_row (
    .clk     (PIXCLK),
    .rst_n   (RST_N),
    .load    (fs_go),
    .org_in  (WIN_Y0),
    .size_in (WIN_H),
    .inc     (in_frame & lv_fall),
    .clr     (fs_go),
    .shift   (decim_q),
    .cnt     (row_cnt),
    .hit     (row_hit),
    .rel     (row_rel)
  );

  always_comb begin
    decim_d    = fs_go ? decim_shift(DECIM) : decim_q;
    pv_d       = in_frame & lv_s1_q & col_hit & row_hit;
    data_out_d = pv_d ? data_s1_q : data_out_q;
    x_d        = pv_d ? col_rel : x_q;
    y_d        = pv_d ? row_rel : y_q;
    fc_d       = fe_go ? fc_q + 1'b1 : fc_q;
    // A fresh error outranks a simultaneous clear.
    line_err_d = (in_frame & lv_fall & (col_cnt != XCW'(H))) |
                 (line_err_q & ~ERR_CLR);
    ovf_err_d  = (in_frame & lv_rise & (row_cnt == YCW'(V))) |
                 (ovf_err_q & ~ERR_CLR);
  end

  always_ff @(posedge PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_SYNC;
      lv_s1_q    <= 1'b0;
      fv_s1_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      lv_p_q     <= 1'b0;
      fv_p_q     <= 1'b0;
      data_s1_q  <= '0;
      decim_q    <= '0;
      data_out_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      fc_q       <= '0;
      line_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lv_s1_q    <= LINE_VALID;
      fv_s1_q    <= FRAME_VALID;
      s1_vld_q   <= 1'b1;
      lv_p_q     <= lv_s1_q;
      fv_p_q     <= fv_s1_q;
      data_s1_q  <= DATA_IN;
      decim_q    <= decim_d;
      data_out_q <= data_out_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pv_q       <= pv_d;
      fs_q       <= fs_go;
      fe_q       <= fe_go;
      fc_q       <= fc_d;
      line_err_q <= line_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign pix.DATA_OUT    = data_out_q;
  assign pix.X_OUT       = x_q;
  assign pix.Y_OUT       = y_q;
  assign pix.PIXEL_VALID = pv_q;
  assign pix.FRAME_START = fs_q;
  assign pix.FRAME_END   = fe_q;
  assign FRAME_COUNT     = fc_q;
  assign LINE_ERR        = line_err_q;
  assign OVF_ERR         = ovf_err_q;
  assign STATE_DBG       = state_q;

endmodule

// File: tb/tb_camera_window.sv
// Directed bench for camera_window on an 8x4 sensor: full window, sub-window,
// decimation, mid-frame reset, line/overflow errors and window latching.
module tb_camera_window;
  import camera_pkg::*;

  localparam int DW  = 10;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int FCW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           lv = 1'b0, fv = 1'b0, err_clr = 1'b0;
  logic [DW-1:0]  din = '0;
  logic [3:0]     x0 = '0, w = '0;
  logic [2:0]     y0 = '0, hh = '0;
  logic [1:0]     dec = '0;
  logic [FCW-1:0] fcount;
  logic           line_err, ovf_err;
  state_t         st;

  camera_window_if #(.DW(DW), .XW(3), .YW(2)) pix ();

  camera_window #(.DW(DW), .H(H), .V(V), .FCW(FCW)) dut (
    .PIXCLK      (clk),
    .RST_N       (rst_n),
    .LINE_VALID  (lv),
    .FRAME_VALID (fv),
    .DATA_IN     (din),
    .WIN_X0      (x0),
    .WIN_W       (w),
    .WIN_Y0      (y0),
    .WIN_H       (hh),
    .DECIM       (dec),
    .ERR_CLR     (err_clr),
    .pix         (pix),
    .FRAME_COUNT (fcount),
    .LINE_ERR    (line_err),
    .OVF_ERR     (ovf_err),
    .STATE_DBG   (st)
  );

  int n_total = 0, n_bad = 0;
  int cyc = 0, fv_cyc = 0, fs_cyc = 0;
  int fs_cnt = 0, fe_cnt = 0, pv_cnt = 0;
  int pv0, fs0, fe0;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input int x, input int y, input int d);
    return {2'(y), 3'(x), 10'(d)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every output beat must match the head of the expected queue
  always @(negedge clk) begin
    logic [14:0] e;
    if (pix.FRAME_START) begin
      fs_cnt++;
      fs_cyc = cyc;
    end
    if (pix.FRAME_END) fe_cnt++;
    if (pix.PIXEL_VALID) begin
      pv_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_pix", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pix", {17'd0, pix.Y_OUT, pix.X_OUT, pix.DATA_OUT}, {17'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int ax0, input int aw, input int ay0, input int ah, input int ad);
    x0 = 4'(ax0); w = 4'(aw); y0 = 3'(ay0); hh = 3'(ah); dec = 2'(ad);
  endtask

  task automatic drive_line(input int l, input int npix, input bit clr);
    for (int c = 0; c < npix; c++) begin
      lv = 1'b1;
      din = 10'(l * 16 + c);
      tick(1);
    end
    lv = 1'b0;
    din = '0;
    tick(1);
    err_clr = clr;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int clr_line, input bit chg);
    fv = 1'b1;
    fv_cyc = cyc;
    tick(2);
    for (int l = 0; l < nlines; l++) begin
      drive_line(l, (l == short_line) ? 7 : 8, l == clr_line);
      if (chg && l == 0) set_win(2, 3, 1, 2, 1);
    end
    fv = 1'b0;
    tick(5);
    @(negedge clk);
  endtask

  task automatic push_full(input int short_line);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < ((y == short_line) ? 7 : 8); x++)
        exp_q.push_back(mk(x, y, y * 16 + x));
  endtask

  task automatic mark();
    pv0 = pv_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
  endtask

  task automatic frame_checks(input string tag, input int npix, input int nfs, input int fc);
    chk({tag, "_npix"}, pv_cnt - pv0, npix);
    chk({tag, "_qleft"}, exp_q.size(), 0);
    chk({tag, "_fs"}, fs_cnt - fs0, nfs);
    chk({tag, "_fe"}, fe_cnt - fe0, nfs);
    chk({tag, "_fcnt"}, fcount, fc);
  endtask

  initial begin
    set_win(0, 8, 0, 4, 0);
    tick(3);
    @(negedge clk);
    chk("rst_state", st, ST_SYNC);
    chk("rst_fcnt", fcount, 0);
    chk("rst_flags", {pix.PIXEL_VALID, pix.FRAME_START, pix.FRAME_END, line_err, ovf_err}, 0);
    chk("rst_data", {pix.DATA_OUT, pix.X_OUT, pix.Y_OUT}, 0);
    rst_n = 1'b1;
    tick(3);
    @(negedge clk);
    chk("armed", st, ST_ARMED);

    // full window, 1:1
    tick(1);
    mark();
    push_full(-1);
    send_frame(4, -1, -1, 1'b0);
    frame_checks("full", 32, 1, 1);
    chk("fs_lat", fs_cyc - fv_cyc, 2);
    chk("full_err", {line_err, ovf_err}, 0);

    // sub-window X0=2 W=3 Y0=1 H=2
    set_win(2, 3, 1, 2, 0);
    mark();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 3; x++)
        exp_q.push_back(mk(x, y, (y + 1) * 16 + x + 2));
    tick(1);
    send_frame(4, -1, -1, 1'b0);
    frame_checks("win", 6, 1, 2);

    // 1:2 decimation, full window
    set_win(0, 8, 0, 4, 1);
    mark();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back(mk(x, y, (2 * y) * 16 + 2 * x));
    tick(1);
    send_frame(4, -1, -1, 1'b0);
    frame_checks("dec2", 8, 1, 3);

    // reset released in the middle of a frame
    set_win(0, 8, 0, 4, 0);
    mark();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_fcnt", fcount, 0);
    chk("rst2_state", st, ST_SYNC);
    tick(1);
    fv = 1'b1;
    tick(2);
    for (int c = 0; c < 8; c++) begin
      lv = 1'b1;
      din = 10'(c);
      if (c == 3) rst_n = 1'b1;
      tick(1);
    end
    lv = 1'b0;
    tick(3);
    drive_line(1, 7, 1'b0);
    drive_line(2, 8, 1'b0);
    fv = 1'b0;
    tick(5);
    @(negedge clk);
    frame_checks("midrst", 0, 0, 0);
    chk("midrst_err", {line_err, ovf_err}, 0);

    // first complete frame after the mid-frame reset
    mark();
    push_full(-1);
    tick(1);
    send_frame(4, -1, -1, 1'b0);
    frame_checks("recov", 32, 1, 1);

    // short line sets LINE_ERR
    mark();
    push_full(1);
    tick(1);
    send_frame(4, 1, -1, 1'b0);
    frame_checks("short", 31, 1, 2);
    chk("short_lerr", line_err, 1);
    chk("short_ovf", ovf_err, 0);
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    @(negedge clk);
    chk("clr_lerr", line_err, 0);

    // second short line with ERR_CLR on the same cycle: error wins
    mark();
    push_full(2);
    tick(1);
    send_frame(4, 2, 2, 1'b0);
    frame_checks("short2", 31, 1, 3);
    chk("short2_lerr", line_err, 1);
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);

    // 5-line frame overflows; window change mid-frame must not apply yet
    mark();
    push_full(-1);
    send_frame(5, -1, -1, 1'b1);
    frame_checks("ovf", 32, 1, 4);
    chk("ovf_err", ovf_err, 1);
    chk("ovf_lerr", line_err, 0);

    // the changed window (X0=2 W=3 Y0=1 H=2, 1:2) applies on the next frame
    mark();
    exp_q.push_back(mk(0, 0, 16 + 2));
    exp_q.push_back(mk(1, 0, 16 + 4));
    tick(1);
    send_frame(4, -1, -1, 1'b0);
    frame_checks("next", 2, 1, 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/camera_window.md
CAMERA_WINDOW -- requirements
Module: camera_window

Interface
REQ-001 Parameter DW, default 10: pixel data width.
REQ-002 Parameter H, default 752: maximum pixels per line.
REQ-003 Parameter V, default 480: maximum lines per frame.
REQ-004 Parameter FCW, default 16: frame counter width.
REQ-005 Port PIXCLK, input, 1: the only clock; all logic SHALL use its rising edge.
REQ-006 Port RST_N, input, 1: reset, asynchronous assert, active-low.
REQ-007 Ports LINE_VALID and FRAME_VALID, input, 1 each: sensor sync.
REQ-008 Port DATA_IN, input, DW: sensor pixel.
REQ-009 Ports WIN_X0 and WIN_W, input, $clog2(H)+1 each: window column origin and width.
REQ-010 Ports WIN_Y0 and WIN_H, input, $clog2(V)+1 each: window line origin and height.
REQ-011 Port DECIM, input, 2: decimation code; 0 = 1:1, 1 = 1:2, 2 = 1:4, 3 = reserved and treated as 0.
REQ-012 Port ERR_CLR, input, 1: clears sticky errors.
REQ-013 Port DATA_OUT, output, DW: pixel.
REQ-014 Ports X_OUT and Y_OUT, output, $clog2(H) and $clog2(V): window-relative, decimated coordinates.
REQ-015 Port PIXEL_VALID, output, 1: DATA_OUT, X_OUT and Y_OUT are valid this cycle.
REQ-016 Ports FRAME_START and FRAME_END, output, 1 each: single-cycle strobes.
REQ-017 Port FRAME_COUNT, output, FCW: number of completed frames.
REQ-018 Ports LINE_ERR and OVF_ERR, output, 1 each: sticky error flags.

Function
REQ-019 LINE_VALID, FRAME_VALID and DATA_IN SHALL be registered once (stage 1); all outputs SHALL be registered from stage 1, giving a fixed 2-cycle latency from input sample to output.
REQ-020 The FSM SHALL have three states: SYNC (wait for FRAME_VALID=0), ARMED (wait for FRAME_VALID rise) and INFRAME.
REQ-021 SYNC -> ARMED when the stage-1 FRAME_VALID is 0, so that a frame already in progress at reset is never captured.
REQ-022 ARMED -> INFRAME on the FRAME_VALID 0->1 edge: latch all WIN_* and DECIM inputs, clear the raw column and line counters, and pulse FRAME_START once.
REQ-023 INFRAME -> ARMED on the FRAME_VALID 1->0 edge: pulse FRAME_END once and increment FRAME_COUNT, wrapping modulo 2^FCW.
REQ-024 Window and decimation values SHALL be constant from frame start to frame end; input changes during a frame take effect at the next frame.
REQ-025 The raw column counter SHALL count pixels while LINE_VALID=1 and clear on LINE_VALID fall.
REQ-026 The raw line counter SHALL increment on each LINE_VALID fall inside INFRAME.
REQ-027 PIXEL_VALID=1 only when all of the following hold: state is INFRAME; LINE_VALID=1; X0 <= col < X0+W; Y0 <= line < Y0+H; col < H; line < V; (col-X0) is a multiple of 2^DECIM; (line-Y0) is a multiple of 2^DECIM.
REQ-028 X_OUT = (col-X0) >> DECIM and Y_OUT = (line-Y0) >> DECIM; the window bound computations SHALL use one extra bit so that X0+W cannot wrap.
REQ-029 WIN_W=0 or WIN_H=0 SHALL produce no PIXEL_VALID for the whole frame; FRAME_START and FRAME_END still pulse.
REQ-030 On LINE_VALID fall in INFRAME, LINE_ERR SHALL be set if the raw column count is not equal to H.
REQ-031 OVF_ERR SHALL be set if a line begins when the line count is already V; the line counter then saturates at V.
REQ-032 ERR_CLR SHALL clear both error flags; a new error in the same cycle SHALL win, leaving the flag set.
REQ-033 LINE_VALID pulses outside INFRAME SHALL be ignored: no counting, no errors, no PIXEL_VALID.

Reset
REQ-034 With RST_N=0, the FSM SHALL be in SYNC, all counters and FRAME_COUNT 0, all outputs 0, and latched window values 0.
REQ-035 Reset deassertion mid-frame SHALL produce no PIXEL_VALID until the next full FRAME_VALID 0->1 edge.

Structure
REQ-036 Package camera_pkg SHALL hold the FSM state encoding and the DECIM code constants.
REQ-037 One sub-module, camera_window_axis, SHALL be instantiated twice (column and line); it contains the raw counter, window compare, decimation mask and relative-coordinate output.

Verification
REQ-038 Bench with H=8 and V=4, a full window and DECIM=0: a 4-line by 8-pixel frame SHALL produce 32 PIXEL_VALID cycles with X 0..7 and Y 0..3, a FRAME_START 2 cycles after the FV rise, and FRAME_COUNT=1.
REQ-039 Window X0=2, W=3, Y0=1, H=2: SHALL produce exactly 6 pixels carrying raw pixels (2..4, 1..2) and X_OUT 0..2, Y_OUT 0..1.
REQ-040 DECIM=1 with a full window on the 8x4 frame: SHALL produce 8 pixels, X_OUT 0..3 and Y_OUT 0..1.
REQ-041 RST_N released with FRAME_VALID=1 mid-frame: SHALL produce no PIXEL_VALID and no FRAME_START until the next frame.
REQ-042 A 7-pixel line SHALL set LINE_ERR; asserting ERR_CLR in the same cycle as a second bad line SHALL leave LINE_ERR=1.
REQ-043 A 5-line frame SHALL set OVF_ERR; window changes mid-frame SHALL not alter the current frame's output.
